// File: rtl/tdm_demux4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tdm_demux4 : 4-channel TDM frame demultiplexer with atomic output update |
// | Optional parity checking with TDM_DEMUX4_PARITY_EN.  Rev 1.0             |
// +--------------------------------------------------------------------------+
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_start,
`ifdef TDM_DEMUX4_PARITY_EN
  input  logic             din_par,
  output logic             par_err,
`endif
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [1:0]       ch,
  output logic             busy,
  output logic             frame_done,
  output logic             resync
);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] sh0_q, sh0_d;
  logic [WIDTH-1:0] sh1_q, sh1_d;
  logic [WIDTH-1:0] sh2_q, sh2_d;
  logic [WIDTH-1:0] q0_q, q0_d;
  logic [WIDTH-1:0] q1_q, q1_d;
  logic [WIDTH-1:0] q2_q, q2_d;
  logic [WIDTH-1:0] q3_q, q3_d;
  logic             frame_done_q, frame_done_d;
  logic             resync_q, resync_d;

`ifdef TDM_DEMUX4_PARITY_EN
  logic             err_flag_q, err_flag_d;
  logic             par_err_q, par_err_d;
  logic             beat_bad;

  // Even parity: din_par must equal the XOR of all data bits.
  assign beat_bad = din_par ^ (^din);
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sh0_d        = sh0_q;
    sh1_d        = sh1_q;
    sh2_d        = sh2_q;
    q0_d         = q0_q;
    q1_d         = q1_q;
    q2_d         = q2_q;
    q3_d         = q3_q;
    frame_done_d = 1'b0;
    resync_d     = 1'b0;
`ifdef TDM_DEMUX4_PARITY_EN
    err_flag_d   = err_flag_q;
    par_err_d    = par_err_q;
`endif

    if (din_valid) begin
      if (frame_start) begin
        // A frame_start beat always opens a fresh frame; any partial one is dropped.
        sh0_d    = din;
        cnt_d    = 2'd1;
        state_d  = S_COLLECT;
        resync_d = (state_q == S_COLLECT);
`ifdef TDM_DEMUX4_PARITY_EN
        err_flag_d = beat_bad;
`endif
      end else if (state_q == S_COLLECT) begin
        case (cnt_q)
          2'd1: begin
            sh1_d = din;
            cnt_d = 2'd2;
`ifdef TDM_DEMUX4_PARITY_EN
            err_flag_d = err_flag_q | beat_bad;
`endif
          end
          2'd2: begin
            sh2_d = din;
            cnt_d = 2'd3;
`ifdef TDM_DEMUX4_PARITY_EN
            err_flag_d = err_flag_q | beat_bad;
`endif
          end
          2'd3: begin
            q0_d         = sh0_q;
            q1_d         = sh1_q;
            q2_d         = sh2_q;
            q3_d         = din;
            cnt_d        = 2'd0;
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
`ifdef TDM_DEMUX4_PARITY_EN
            par_err_d  = err_flag_q | beat_bad;
            err_flag_d = 1'b0;
`endif
          end
          default: begin
            cnt_d = cnt_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 2'd0;
      sh0_q        <= '0;
      sh1_q        <= '0;
      sh2_q        <= '0;
      q0_q         <= '0;
      q1_q         <= '0;
      q2_q         <= '0;
      q3_q         <= '0;
      frame_done_q <= 1'b0;
      resync_q     <= 1'b0;
`ifdef TDM_DEMUX4_PARITY_EN
      err_flag_q   <= 1'b0;
      par_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh0_q        <= sh0_d;
      sh1_q        <= sh1_d;
      sh2_q        <= sh2_d;
      q0_q         <= q0_d;
      q1_q         <= q1_d;
      q2_q         <= q2_d;
      q3_q         <= q3_d;
      frame_done_q <= frame_done_d;
      resync_q     <= resync_d;
`ifdef TDM_DEMUX4_PARITY_EN
      err_flag_q   <= err_flag_d;
      par_err_q    <= par_err_d;
`endif
    end
  end

  assign q0         = q0_q;
  assign q1         = q1_q;
  assign q2         = q2_q;
  assign q3         = q3_q;
  assign ch         = cnt_q;
  assign busy       = (state_q == S_COLLECT);
  assign frame_done = frame_done_q;
  assign resync     = resync_q;
`ifdef TDM_DEMUX4_PARITY_EN
  assign par_err    = par_err_q;
`endif

endmodule
`default_nettype wire
